// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, sequencer state encoding and stage-control helpers
package cpu_pkg;

    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_BR  = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Encodings are fixed so debug logic can decode the raw state bits.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } pipe_state_t;

    // Load enables and bubble-inject requests for every pipeline register.
    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic mem_wb_we;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } stage_ctl_t;

    // Nothing moves.
    function automatic stage_ctl_t ctl_freeze();
        stage_ctl_t c;
        c = '0;
        return c;
    endfunction

    // Every stage advances normally.
    function automatic stage_ctl_t ctl_advance();
        stage_ctl_t c;
        c = '0;
        c.pc_we     = 1'b1;
        c.if_id_we  = 1'b1;
        c.id_ex_we  = 1'b1;
        c.ex_mem_we = 1'b1;
        c.mem_wb_we = 1'b1;
        return c;
    endfunction

    // Taken branch: advance everything, replace the three younger instrs with NOPs.
    function automatic stage_ctl_t ctl_squash();
        stage_ctl_t c;
        c = ctl_advance();
        c.if_id_flush  = 1'b1;
        c.id_ex_flush  = 1'b1;
        c.ex_mem_flush = 1'b1;
        return c;
    endfunction

    // Hold PC and IF/ID, push a bubble into ID/EX, let older instrs retire.
    function automatic stage_ctl_t ctl_hold_front();
        stage_ctl_t c;
        c = ctl_advance();
        c.pc_we       = 1'b0;
        c.if_id_we    = 1'b0;
        c.id_ex_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard compare between ID/EX and IF/ID
module hazard_detect
    import cpu_pkg::*;
(
    input  logic [3:0] ex_op,
    input  logic [3:0] ex_rd,
    input  logic [3:0] id_rs,
    input  logic [3:0] id_rt,
    input  logic       id_rt_used,
    output logic       load_use
);

    logic ex_is_load;
    logic rs_hit;
    logic rt_hit;

    // A load whose result the next instr needs; r0 is never a real dependency.
    always_comb begin
        ex_is_load = (ex_op == OP_LW) && (ex_rd != 4'd0);
        rs_hit     = (ex_rd == id_rs);
        rt_hit     = id_rt_used && (ex_rd == id_rt);
        load_use   = ex_is_load && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_op,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic             id_rt_used,
    input  logic [3:0]       ex_op,
    input  logic [3:0]       ex_rd,
    input  logic             mem_br,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    // The HLT cycle in RUN already behaves like one drain cycle.
    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYC - 1);

    pipe_state_t      state_q;
    pipe_state_t      state_d;
    logic [3:0]       drain_cnt_q;
    logic [3:0]       drain_cnt_d;
    logic             ret_drain_q;
    logic             ret_drain_d;
    logic [CNT_W-1:0] stall_cnt_q;
    stage_ctl_t       ctl;
    logic             run_mode;
    logic             drain_mode;
    logic             load_use;
    logic             stall_inc;

    hazard_detect u_hazard_detect (
        .ex_op      (ex_op),
        .ex_rd      (ex_rd),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rt_used (id_rt_used),
        .load_use   (load_use)
    );

    // Next state and stage control; DWAIT with memory free reuses RUN/DRAIN rules.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        ret_drain_d = ret_drain_q;
        ctl         = ctl_freeze();
        run_mode    = 1'b0;
        drain_mode  = 1'b0;

        case (state_q)
            ST_RUN:   run_mode = 1'b1;
            ST_DRAIN: drain_mode = 1'b1;
            ST_DWAIT: begin
                if (!dmem_busy) begin
                    if (ret_drain_q) begin
                        drain_mode = 1'b1;
                    end else begin
                        run_mode = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (run_mode) begin
            if (dmem_busy) begin
                ctl         = ctl_freeze();
                state_d     = ST_DWAIT;
                ret_drain_d = 1'b0;
            end else if (mem_br) begin
                ctl     = ctl_squash();
                state_d = ST_RUN;
            end else if (imem_busy || load_use) begin
                ctl     = ctl_hold_front();
                state_d = ST_RUN;
            end else if (id_op == OP_HLT) begin
                ctl         = ctl_hold_front();
                state_d     = ST_DRAIN;
                drain_cnt_d = DRAIN_INIT;
            end else begin
                ctl     = ctl_advance();
                state_d = ST_RUN;
            end
        end else if (drain_mode) begin
            if (dmem_busy) begin
                // Drain progress is held until the data access completes.
                ctl         = ctl_freeze();
                state_d     = ST_DWAIT;
                ret_drain_d = 1'b1;
            end else if (mem_br) begin
                // A branch older than HLT wins: the HLT itself gets squashed.
                ctl         = ctl_squash();
                state_d     = ST_RUN;
                ret_drain_d = 1'b0;
            end else begin
                ctl         = ctl_hold_front();
                drain_cnt_d = drain_cnt_q - 4'd1;
                state_d     = (drain_cnt_q <= 4'd1) ? ST_HALT : ST_DRAIN;
            end
        end
    end

    // HALT never counts: only stalls of a live pipeline are performance loss.
    always_comb begin
        stall_inc = (state_q != ST_HALT) && !ctl.pc_we;
    end

    // Sequencer state and drain counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= 4'd0;
            ret_drain_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            ret_drain_q <= ret_drain_d;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    // Outputs are forced idle while reset is asserted, independent of the clock.
    always_comb begin
        pc_we        = rst & ctl.pc_we;
        if_id_we     = rst & ctl.if_id_we;
        id_ex_we     = rst & ctl.id_ex_we;
        ex_mem_we    = rst & ctl.ex_mem_we;
        mem_wb_we    = rst & ctl.mem_wb_we;
        if_id_flush  = rst & ctl.if_id_flush;
        id_ex_flush  = rst & ctl.id_ex_flush;
        ex_mem_flush = rst & ctl.ex_mem_flush;
        halted       = (state_q == ST_HALT);
        stall_cnt    = stall_cnt_q;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

    // {pc,if_id,id_ex,ex_mem,mem_wb _we, if_id,id_ex,ex_mem _flush, halted}
    localparam logic [8:0] C_ALL  = 9'b11111_000_0;
    localparam logic [8:0] C_FRZ  = 9'b00000_000_0;
    localparam logic [8:0] C_HOLD = 9'b00111_010_0;
    localparam logic [8:0] C_BR   = 9'b11111_111_0;
    localparam logic [8:0] C_HLTD = 9'b00000_000_1;

    typedef struct {
        string      tag;
        logic [8:0] ctl;
        logic [3:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] id_op = '0, id_rs = '0, id_rt = '0, ex_op = '0, ex_rd = '0;
    logic       id_rt_used = 1'b0, mem_br = 1'b0, imem_busy = 1'b0, dmem_busy = 1'b0;
    logic       pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, halted;
    logic [3:0] stall_cnt;
    logic [8:0] obs_ctl;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    pipe_ctrl #(.CNT_W(4), .DRAIN_CYC(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_op        (id_op),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rt_used   (id_rt_used),
        .ex_op        (ex_op),
        .ex_rd        (ex_rd),
        .mem_br       (mem_br),
        .imem_busy    (imem_busy),
        .dmem_busy    (dmem_busy),
        .pc_we        (pc_we),
        .if_id_we     (if_id_we),
        .id_ex_we     (id_ex_we),
        .ex_mem_we    (ex_mem_we),
        .mem_wb_we    (mem_wb_we),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .halted       (halted),
        .stall_cnt    (stall_cnt)
    );

    assign obs_ctl = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                      if_id_flush, id_ex_flush, ex_mem_flush, halted};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [8:0] ectl, input logic [3:0] ecnt);
        vectors++;
        assert (obs_ctl === ectl) else begin
            miscompares++;
            $error("FAIL %s ctl observed=%b expected=%b", tag, obs_ctl, ectl);
        end
        vectors++;
        assert (stall_cnt === ecnt) else begin
            miscompares++;
            $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, ecnt);
        end
    endtask

    task automatic clr();
        id_op = '0; id_rs = '0; id_rt = '0; id_rt_used = 1'b0;
        ex_op = '0; ex_rd = '0; mem_br = 1'b0; imem_busy = 1'b0; dmem_busy = 1'b0;
    endtask

    // Inputs already driven; queue the expectation, compare at the falling edge.
    task automatic step(input string tag, input logic [8:0] ectl, input logic [3:0] ecnt);
        exp_t e;
        e.tag = tag; e.ctl = ectl; e.cnt = ecnt;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = sb.pop_front();
            chk(e.tag, e.ctl, e.cnt);
        end
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge: assert reset mid-cycle, check, release.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        chk(tag, C_FRZ, 4'd0);
        clr();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        #3;
        chk("por", C_FRZ, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset asserted while waiting on data memory
        dmem_busy = 1'b1;
        step("dwait0", C_FRZ, 4'd0);
        step("dwait1", C_FRZ, 4'd1);
        dmem_busy = 1'b1;
        do_reset("rst_dwait");
        step("rst_release", C_ALL, 4'd0);

        // Load-use on rs and rt; r0 and stores never stall
        clr(); ex_op = 4'h8; ex_rd = 4'd3; id_rs = 4'd3;
        step("lu_rs", C_HOLD, 4'd0);
        ex_rd = 4'd0; id_rs = 4'd0;
        step("lu_r0", C_ALL, 4'd1);
        clr(); ex_op = 4'h8; ex_rd = 4'd5; id_rt = 4'd5; id_rt_used = 1'b1;
        step("lu_rt", C_HOLD, 4'd1);
        id_rt_used = 1'b0;
        step("lu_rt_unused", C_ALL, 4'd2);
        clr(); ex_op = 4'h9; ex_rd = 4'd3; id_rs = 4'd3;
        step("sw_no_lu", C_ALL, 4'd2);

        // dmem_busy dominates imem_busy, then imem rule on exit
        clr(); dmem_busy = 1'b1; imem_busy = 1'b1;
        for (int i = 0; i < 4; i++) step("dmem_imem", C_FRZ, 4'(2 + i));
        dmem_busy = 1'b0;
        step("dwait_exit_imem", C_HOLD, 4'd6);
        clr();
        step("resume", C_ALL, 4'd7);

        // Taken branch beats load-use and imem stall
        ex_op = 4'h8; ex_rd = 4'd3; id_rs = 4'd3; mem_br = 1'b1;
        step("br_over_lu", C_BR, 4'd7);
        imem_busy = 1'b1;
        step("br_over_imem", C_BR, 4'd7);
        clr();
        step("post_br", C_ALL, 4'd7);

        // HLT drain, 3 cycles to halted; HALT does not count stalls
        id_op = 4'hF;
        step("hlt_id", C_HOLD, 4'd7);
        clr();
        step("drain1", C_HOLD, 4'd8);
        step("drain2", C_HOLD, 4'd9);
        step("halted", C_HLTD, 4'd10);
        id_op = 4'hF; imem_busy = 1'b1;
        step("halt_hold", C_HLTD, 4'd10);
        do_reset("rst_halt");

        // dmem_busy for 2 cycles inside DRAIN delays halted by 2
        id_op = 4'hF;
        step("hlt2_id", C_HOLD, 4'd0);
        clr();
        step("drain2_1", C_HOLD, 4'd1);
        dmem_busy = 1'b1;
        step("drain_dmem0", C_FRZ, 4'd2);
        step("drain_dmem1", C_FRZ, 4'd3);
        dmem_busy = 1'b0;
        step("drain_resume", C_HOLD, 4'd4);
        step("halted_late", C_HLTD, 4'd5);
        step("halted_late2", C_HLTD, 4'd5);
        do_reset("rst_halt2");

        // Older branch squashes HLT during DRAIN
        id_op = 4'hF;
        step("hlt3_id", C_HOLD, 4'd0);
        clr(); mem_br = 1'b1;
        step("drain_br", C_BR, 4'd1);
        clr();
        step("drain_br_run", C_ALL, 4'd1);
        do_reset("rst_sat");

        // Stall counter saturates at 15 with CNT_W=4
        imem_busy = 1'b1;
        for (int i = 0; i < 20; i++) step("sat", C_HOLD, (i > 15) ? 4'd15 : 4'(i));
        clr();
        step("sat_hold", C_ALL, 4'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
